// File: rtl/rx_comma_align.sv
// rx_comma_align: serial K28.5 comma aligner.
// Bits arrive LSB first. The incoming bit can be inverted with RXPOL before it
// enters a 10-bit shift register. A phase counter tracks the symbol boundary.
// A three-state FSM hunts for a comma, confirms repeated commas at one phase,
// and then outputs one aligned symbol every ten bits. Misaligned commas seen
// while locked are counted, and enough of them drop the lock.

// Protocol checker for the registered outputs of the aligner.
module rx_comma_align_chk (
    input logic reloj,
    input logic reset_n,
    input logic valid,
    input logic is_comma,
    input logic align_err
);

    // valid is a single-cycle pulse; symbols are at least ten bits apart.
    property p_valid_single;
        @(posedge reloj) disable iff (!reset_n) valid |=> !valid;
    endproperty

    // is_comma only qualifies an output symbol.
    property p_comma_qualified;
        @(posedge reloj) disable iff (!reset_n) is_comma |-> valid;
    endproperty

    // A misaligned comma is by definition never on an output boundary.
    property p_err_off_boundary;
        @(posedge reloj) disable iff (!reset_n) align_err |-> !valid;
    endproperty

    a_valid_single:     assert property (p_valid_single);
    a_comma_qualified:  assert property (p_comma_qualified);
    a_err_off_boundary: assert property (p_err_off_boundary);

endmodule

module rx_comma_align #(
    parameter int LOCK_COMMAS = 3,
    parameter int ERR_LIMIT   = 4
) (
    input  logic       reloj,
    input  logic       reset_n,
    input  logic       data_in,
    input  logic       RXPOL,
    output logic [9:0] data_out,
    output logic       valid,
    output logic       is_comma,
    output logic       locked,
    output logic       align_err
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;
    localparam logic [3:0] SYM_LAST  = 4'd9;
    localparam logic [3:0] LOCK_LIM  = 4'(LOCK_COMMAS);
    localparam logic [3:0] ERR_LIM   = 4'(ERR_LIMIT);

    // Either running-disparity form of K28.5 counts as a comma.
    function automatic logic is_k28_5(input logic [9:0] sym);
        return (sym == K28_5_RDN) || (sym == K28_5_RDP);
    endfunction

    // 4-bit increment that sticks at its maximum instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : (v + 4'd1);
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [9:0] sr_r;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic [3:0] cnt_adv_s;
    logic [3:0] good_cnt_r;
    logic [3:0] good_cnt_s;
    logic [3:0] good_inc_s;
    logic [3:0] err_cnt_r;
    logic [3:0] err_cnt_s;
    logic [3:0] err_inc_s;
    logic       rx_bit_s;
    logic       comma_hit_s;
    logic       boundary_s;
    logic [9:0] data_out_s;
    logic       valid_s;
    logic       is_comma_s;
    logic       locked_s;
    logic       align_err_s;

    assign rx_bit_s    = data_in ^ RXPOL;
    assign comma_hit_s = is_k28_5(sr_r);
    assign boundary_s  = (cnt_r == 4'd0);
    assign cnt_adv_s   = (cnt_r >= SYM_LAST) ? 4'd0 : (cnt_r + 4'd1);
    assign good_inc_s  = sat_inc4(good_cnt_r);
    assign err_inc_s   = sat_inc4(err_cnt_r);

    // Deserialiser: newest bit enters at the top, so sr_r[0] is the oldest bit.
    always_ff @(posedge reloj) begin
        if (!reset_n) begin
            sr_r <= 10'd0;
        end else begin
            sr_r <= {rx_bit_s, sr_r[9:1]};
        end
    end

    // Registers for the FSM state, its counters and every output.
    always_ff @(posedge reloj) begin
        if (!reset_n) begin
            state_r    <= ST_HUNT;
            cnt_r      <= 4'd0;
            good_cnt_r <= 4'd0;
            err_cnt_r  <= 4'd0;
            data_out   <= 10'd0;
            valid      <= 1'b0;
            is_comma   <= 1'b0;
            locked     <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            good_cnt_r <= good_cnt_s;
            err_cnt_r  <= err_cnt_s;
            data_out   <= data_out_s;
            valid      <= valid_s;
            is_comma   <= is_comma_s;
            locked     <= locked_s;
            align_err  <= align_err_s;
        end
    end

    // Next-state and next-output logic; an aligned comma (cnt_r == 0) always wins.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_adv_s;
        good_cnt_s  = good_cnt_r;
        err_cnt_s   = err_cnt_r;
        data_out_s  = data_out;
        valid_s     = 1'b0;
        is_comma_s  = 1'b0;
        align_err_s = 1'b0;

        case (state_r)
            ST_HUNT: begin
                if (comma_hit_s) begin
                    state_s    = ST_CHECK;
                    cnt_s      = 4'd1;
                    good_cnt_s = 4'd1;
                end else begin
                    cnt_s = 4'd0;
                end
            end

            ST_CHECK: begin
                if (comma_hit_s && boundary_s) begin
                    good_cnt_s = good_inc_s;
                    if (good_inc_s >= LOCK_LIM) begin
                        state_s   = ST_LOCKED;
                        err_cnt_s = 4'd0;
                    end else begin
                        state_s = ST_CHECK;
                    end
                end else if (comma_hit_s) begin
                    // The comma arrived at another phase: restart confirmation there.
                    cnt_s      = 4'd1;
                    good_cnt_s = 4'd1;
                end else begin
                    good_cnt_s = good_cnt_r;
                end
            end

            ST_LOCKED: begin
                if (boundary_s) begin
                    data_out_s = sr_r;
                    valid_s    = 1'b1;
                    is_comma_s = comma_hit_s;
                    if (comma_hit_s) begin
                        err_cnt_s = 4'd0;
                    end else begin
                        err_cnt_s = err_cnt_r;
                    end
                end else if (comma_hit_s) begin
                    // Keep the current phase until enough misaligned commas accumulate.
                    align_err_s = 1'b1;
                    err_cnt_s   = err_inc_s;
                    if (err_inc_s >= ERR_LIM) begin
                        state_s    = ST_HUNT;
                        cnt_s      = 4'd0;
                        good_cnt_s = 4'd0;
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end else begin
                    err_cnt_s = err_cnt_r;
                end
            end

            default: begin
                state_s    = ST_HUNT;
                cnt_s      = 4'd0;
                good_cnt_s = 4'd0;
                err_cnt_s  = 4'd0;
            end
        endcase

        locked_s = (state_s == ST_LOCKED);
    end

    rx_comma_align_chk u_chk (
        .reloj     (reloj),
        .reset_n   (reset_n),
        .valid     (valid),
        .is_comma  (is_comma),
        .align_err (align_err)
    );

endmodule

// File: tb/tb_rx_comma_align.sv
// Testbench for rx_comma_align: directed symbol table, hand-written slip and
// reset sequences, and a randomized stream checked every cycle against a
// bit-history reference model.
module tb_rx_comma_align;

    localparam int LOCK_N    = 3;
    localparam int ERR_N     = 4;
    localparam int ST_HUNT   = 0;
    localparam int ST_CHECK  = 1;
    localparam int ST_LOCKED = 2;
    localparam logic [9:0] COMMA_N = 10'h17C;
    localparam logic [9:0] COMMA_P = 10'h283;
    localparam logic [9:0] D_A     = 10'h2AA;
    localparam logic [9:0] D_B     = 10'h155;

    logic       reloj   = 1'b0;
    logic       reset_n = 1'b0;
    logic       data_in = 1'b0;
    logic       RXPOL   = 1'b0;
    logic [9:0] data_out;
    logic       valid;
    logic       is_comma;
    logic       locked;
    logic       align_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    rx_comma_align #(.LOCK_COMMAS(LOCK_N), .ERR_LIMIT(ERR_N)) dut (
        .reloj     (reloj),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .RXPOL     (RXPOL),
        .data_out  (data_out),
        .valid     (valid),
        .is_comma  (is_comma),
        .locked    (locked),
        .align_err (align_err)
    );

    always #5 reloj = ~reloj;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    // Kept as: the last ten received bits, the edge index at which the symbol
    // phase was last anchored, and plain integer counters.
    bit         hist[$];
    int         m_t      = 0;
    int         m_anchor = 0;
    int         m_state  = ST_HUNT;
    int         m_good   = 0;
    int         m_err    = 0;
    logic [9:0] m_data   = 10'd0;
    logic       m_valid  = 1'b0;
    logic       m_comma  = 1'b0;
    logic       m_locked = 1'b0;
    logic       m_aerr   = 1'b0;

    function automatic logic [9:0] m_window();
        logic [9:0] w;
        int n;
        int idx;
        n = hist.size();
        for (int i = 0; i < 10; i++) begin
            idx  = n - 10 + i;
            w[i] = (idx >= 0) ? hist[idx] : 1'b0;
        end
        return w;
    endfunction

    task automatic model_step();
        logic [9:0] w;
        logic       hit;
        logic       bnd;
        bit         b;
        b = data_in ^ RXPOL;
        if (!reset_n) begin
            hist.delete();
            m_state = ST_HUNT; m_good = 0; m_err = 0;
            m_data = 10'd0; m_valid = 1'b0; m_comma = 1'b0; m_locked = 1'b0; m_aerr = 1'b0;
        end else begin
            w   = m_window();
            hit = (w == COMMA_N) || (w == COMMA_P);
            bnd = (m_state != ST_HUNT) && (m_t > m_anchor) && (((m_t - m_anchor) % 10) == 0);
            m_valid = 1'b0; m_comma = 1'b0; m_aerr = 1'b0;
            case (m_state)
                ST_HUNT: if (hit) begin m_state = ST_CHECK; m_anchor = m_t; m_good = 1; end
                ST_CHECK: begin
                    if (hit && bnd) begin
                        m_good = (m_good < 15) ? m_good + 1 : 15;
                        if (m_good >= LOCK_N) begin m_state = ST_LOCKED; m_err = 0; end
                    end else if (hit) begin
                        m_anchor = m_t; m_good = 1;
                    end
                end
                ST_LOCKED: begin
                    if (bnd) begin
                        m_valid = 1'b1; m_data = w; m_comma = hit;
                        if (hit) m_err = 0;
                    end else if (hit) begin
                        m_aerr = 1'b1;
                        m_err  = (m_err < 15) ? m_err + 1 : 15;
                        if (m_err >= ERR_N) begin m_state = ST_HUNT; m_good = 0; end
                    end
                end
                default: m_state = ST_HUNT;
            endcase
            m_locked = (m_state == ST_LOCKED);
            hist.push_back(b);
            if (hist.size() > 10) void'(hist.pop_front());
        end
        m_t++;
    endtask

    always @(posedge reloj) model_step();

    // Every-cycle comparison of all outputs against the model.
    always @(negedge reloj)
        check("model", {18'd0, data_out, valid, is_comma, locked, align_err},
              {18'd0, m_data, m_valid, m_comma, m_locked, m_aerr});

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge reloj);
        #1;
        cyc++;
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int b = 0; b < 10; b++) send_bit(s[b]);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        data_in = 1'b0;
        repeat (n) begin @(posedge reloj); #1; cyc++; end
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [9:0] sym;
        logic       pol;
        logic       e_valid;
        logic [9:0] e_data;
        logic       e_comma;
        logic       e_locked;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(input logic [9:0] s, input logic p, input logic v,
                                input logic [9:0] d, input logic c, input logic l);
        vec_t r;
        r.sym = s; r.pol = p; r.e_valid = v; r.e_data = d; r.e_comma = c; r.e_locked = l;
        return r;
    endfunction

    task automatic check_rec(input int j);
        check($sformatf("vec%0d valid", j),    valid,    vt[j].e_valid);
        check($sformatf("vec%0d data_out", j), data_out, vt[j].e_data);
        check($sformatf("vec%0d is_comma", j), is_comma, vt[j].e_comma);
        check($sformatf("vec%0d locked", j),   locked,   vt[j].e_locked);
    endtask

    // Each record's outputs appear on the edge that samples the next record's first bit.
    task automatic apply_range(input int lo, input int hi);
        do_reset(2);
        for (int i = lo; i <= hi; i++) begin
            for (int b = 0; b < 10; b++) begin
                RXPOL = vt[i].pol;
                send_bit(vt[i].sym[b]);
                if (b == 0 && i > lo) check_rec(i - 1);
            end
        end
        send_bit(1'b0);
        check_rec(hi);
    endtask

    initial begin
        logic [9:0] sym;
        int n_aerr;
        int t4;
        int t_relock;
        int n_valid;
        logic prev_locked;
        int r;
        int r2;

        // Plain lock, then a data symbol and a comma at the locked phase.
        vt[0]  = mk(COMMA_N, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0);
        vt[1]  = mk(COMMA_N, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0);
        vt[2]  = mk(COMMA_N, 1'b0, 1'b0, 10'd0,   1'b0, 1'b1);
        vt[3]  = mk(D_A,     1'b0, 1'b1, D_A,     1'b0, 1'b1);
        vt[4]  = mk(COMMA_N, 1'b0, 1'b1, COMMA_N, 1'b1, 1'b1);
        // Inverted line: 0x283 on the wire decodes as 0x17C.
        vt[5]  = mk(COMMA_P, 1'b1, 1'b0, 10'd0,   1'b0, 1'b0);
        vt[6]  = mk(COMMA_P, 1'b1, 1'b0, 10'd0,   1'b0, 1'b0);
        vt[7]  = mk(COMMA_P, 1'b1, 1'b0, 10'd0,   1'b0, 1'b1);
        vt[8]  = mk(COMMA_P, 1'b1, 1'b1, COMMA_N, 1'b1, 1'b1);
        vt[9]  = mk(D_B,     1'b1, 1'b1, D_A,     1'b0, 1'b1);
        // Data between commas at the boundary does not disturb confirmation.
        vt[10] = mk(COMMA_N, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0);
        vt[11] = mk(D_A,     1'b0, 1'b0, 10'd0,   1'b0, 1'b0);
        vt[12] = mk(D_B,     1'b0, 1'b0, 10'd0,   1'b0, 1'b0);
        vt[13] = mk(COMMA_N, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0);
        vt[14] = mk(COMMA_N, 1'b0, 1'b0, 10'd0,   1'b0, 1'b1);
        vt[15] = mk(D_A,     1'b0, 1'b1, D_A,     1'b0, 1'b1);

        // Reset state.
        do_reset(3);
        check("reset data_out",  data_out,  10'd0);
        check("reset valid",     valid,     1'b0);
        check("reset is_comma",  is_comma,  1'b0);
        check("reset locked",    locked,    1'b0);
        check("reset align_err", align_err, 1'b0);

        apply_range(0, 4);
        apply_range(5, 9);
        apply_range(10, 15);

        // 3-bit slip while locked, then commas at the new phase.
        RXPOL = 1'b0;
        do_reset(2);
        repeat (3) send_sym(COMMA_N);
        send_sym(D_A);
        send_bit(1'b1);
        check("pre-slip locked", locked, 1'b1);
        check("pre-slip valid", valid, 1'b1);
        check("pre-slip data_out", data_out, D_A);
        send_bit(1'b0);
        send_bit(1'b1);
        n_aerr = 0; t4 = -1000; t_relock = -1; prev_locked = locked;
        sym = COMMA_N;
        for (int k = 0; k < 8; k++) begin
            for (int b = 0; b < 10; b++) begin
                send_bit(sym[b]);
                if (align_err) begin
                    n_aerr++;
                    check($sformatf("locked at align_err #%0d", n_aerr), locked, (n_aerr < ERR_N));
                    if (n_aerr == ERR_N) t4 = cyc;
                end
                if (locked && !prev_locked && t4 >= 0 && t_relock < 0) t_relock = cyc;
                prev_locked = locked;
            end
        end
        check("align_err pulse count", n_aerr, 4);
        check("relock delay cycles", t_relock - t4, 30);

        // One-cycle reset in the middle of a symbol while locked.
        check("locked before reset", locked, 1'b1);
        for (int b = 0; b < 4; b++) send_bit(sym[b]);
        reset_n = 1'b0;
        send_bit(sym[4]);
        reset_n = 1'b1;
        check("mid reset data_out",  data_out,  10'd0);
        check("mid reset valid",     valid,     1'b0);
        check("mid reset is_comma",  is_comma,  1'b0);
        check("mid reset locked",    locked,    1'b0);
        check("mid reset align_err", align_err, 1'b0);
        n_valid = 0;
        for (int b = 5; b < 10; b++) begin send_bit(sym[b]); n_valid += int'(valid); end
        for (int k = 0; k < 3; k++)
            for (int b = 0; b < 10; b++) begin send_bit(sym[b]); n_valid += int'(valid); end
        sym = D_A;
        send_bit(sym[0]);
        n_valid += int'(valid);
        check("relock after reset", locked, 1'b1);
        check("no valid before relock", n_valid, 0);
        for (int b = 1; b < 10; b++) send_bit(sym[b]);
        send_bit(1'b0);
        check("first valid after reset", valid, 1'b1);
        check("first data after reset", data_out, D_A);
        check("first is_comma after reset", is_comma, 1'b0);

        // Randomized stream: commas, random symbols, slips, bit errors,
        // polarity flips and short resets, all checked by the model.
        do_reset(2);
        for (int s = 0; s < 2500; s++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                reset_n = 1'b0;
                send_bit(1'($urandom_range(0, 1)));
                reset_n = 1'b1;
            end else if (r < 5) begin
                RXPOL = ~RXPOL;
            end else if (r < 9) begin
                repeat ($urandom_range(1, 9)) send_bit(1'($urandom_range(0, 1)));
            end else begin
                r2 = int'($urandom_range(0, 99));
                if (r2 < 55) sym = ($urandom_range(0, 1) == 0) ? COMMA_N : COMMA_P;
                else sym = 10'($urandom_range(0, 1023));
                if (r2 % 17 == 0) sym[$urandom_range(0, 9)] ^= 1'b1;
                send_sym(sym ^ {10{RXPOL}});
            end
        end
        repeat (12) send_bit(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_comma_align.md
RX_COMMA_ALIGN -- requirements
Module: rx_comma_align

Interface
REQ-001 SHALL have parameter LOCK_COMMAS, default 3, meaning the number of consecutive phase-consistent commas needed to declare lock (range 1..15).
REQ-002 SHALL have parameter ERR_LIMIT, default 4, meaning the number of misaligned commas in LOCKED that forces loss of lock (range 1..15).
REQ-003 SHALL have port reloj, input, 1, the bit clock; single clock domain with all logic on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-005 SHALL have port data_in, input, 1, the serial line, LSB (bit a) first.
REQ-006 SHALL have port RXPOL, input, 1; when 1, each received bit is inverted before use.
REQ-007 SHALL have port data_out, output, 10, the last aligned symbol, registered.
REQ-008 SHALL have port valid, output, 1, a one-cycle pulse that qualifies data_out.
REQ-009 SHALL have port is_comma, output, 1, asserted together with valid when data_out is a comma.
REQ-010 SHALL have port locked, output, 1, high while the FSM is in LOCKED.
REQ-011 SHALL have port align_err, output, 1, a one-cycle pulse on each misaligned comma while in LOCKED.

Function
REQ-012 SHALL shift one bit per reloj edge into a 10-bit register sr: sr <= {data_in^RXPOL, sr[9:1]}, so sr[0] holds the oldest bit.
REQ-013 SHALL raise the combinational comma_hit when sr equals 10'h17C (K28.5 RD-) or 10'h283 (K28.5 RD+).
REQ-014 SHALL keep a phase counter cnt counting 0..9 and wrapping 9->0; the symbol boundary is cnt==0.
REQ-015 SHALL implement FSM states HUNT, CHECK and LOCKED, with good_cnt and err_cnt each 4 bits and saturating.
REQ-016 HUNT: on comma_hit, go to CHECK with cnt<=1 and good_cnt<=1; otherwise cnt holds at 0.
REQ-017 CHECK: a comma_hit at the boundary increments good_cnt; when it reaches LOCK_COMMAS, go to LOCKED with err_cnt<=0.
REQ-018 CHECK: a comma_hit off the boundary realigns (cnt<=1, good_cnt<=1) and the FSM stays in CHECK.
REQ-019 CHECK: a non-comma symbol at the boundary is ignored and good_cnt holds.
REQ-020 LOCKED: at every boundary, data_out<=sr and valid<=1; is_comma<=comma_hit.
REQ-021 LOCKED: a comma_hit at the boundary clears err_cnt.
REQ-022 LOCKED: a comma_hit off the boundary pulses align_err and increments err_cnt; when err_cnt reaches ERR_LIMIT, go to HUNT with cnt<=0 and good_cnt<=0, and the current-phase alignment is kept until then.
REQ-023 SHALL assert valid only for boundaries evaluated in LOCKED; the comma that completes lock is not output.
REQ-024 Latency: when the last bit of a symbol is sampled on edge k, data_out and valid SHALL update on edge k+1.
REQ-025 valid SHALL never pulse on two consecutive cycles; pulses SHALL be spaced exactly 10 cycles apart while alignment is held.
REQ-026 data_out SHALL hold its value between valid pulses; locked is registered and SHALL change on the edge of the state transition.
REQ-027 A change of RXPOL mid-stream SHALL affect the next sampled bit only and SHALL NOT reset the FSM or the counters.
REQ-028 When aligned and misaligned comma conditions coincide, the aligned interpretation (cnt==0) SHALL take precedence.

Reset
REQ-029 When reset_n==0 at a rising edge: sr<=0, cnt<=0, good_cnt<=0, err_cnt<=0, state<=HUNT, data_out<=0, and valid, is_comma, locked and align_err <=0.
REQ-030 Reset SHALL dominate all other conditions; reset asserted mid-symbol SHALL discard partial data and yield no valid on the following edge.
REQ-031 After reset release, the FSM SHALL require a fresh comma in HUNT before any valid.

Verification
REQ-032 Send 3x K28.5 RD- (0x17C, LSB first) then D-symbol 0x2AA -> locked rises after the 3rd comma; next valid shows data_out=0x2AA, is_comma=0.
REQ-033 Set RXPOL=1 and send inverted commas (0x283 on the wire) -> lock is achieved and the comma decodes as 0x17C with is_comma=1.
REQ-034 After lock, insert a 3-bit slip and then send commas at the new phase -> align_err pulses 4 times, locked falls on the 4th, and relock follows 3 commas later.
REQ-035 Send comma, 2 data symbols, comma -> good_cnt=2 and the FSM stays in CHECK; a 3rd aligned comma -> LOCKED.
REQ-036 Pull reset_n low for 1 cycle mid-symbol while LOCKED -> all outputs are 0 on the next edge, and valid stays 0 until 3 new commas have been received.
